// File: rtl/pc_stream_serializer_rr.sv
// N-input round-robin serializer: each granted message is split into NPCdata-bit
// chunks, tagged with CODE_BASE+stream and sent LS chunk first, never interleaved.
module pc_stream_serializer_rr #(
    parameter int NIN       = 4,
    parameter int Nin       = 48,
    parameter int NPCcode   = 8,
    parameter int NPCdata   = 24,
    parameter int CODE_BASE = 14
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NIN*Nin-1:0]   in_d,
    input  logic [NIN-1:0]       in_v,
    output logic [NIN-1:0]       in_a,
    input  logic [NIN-1:0]       enable,
    output logic [NPCcode-1:0]   out_code,
    output logic [NPCdata-1:0]   out_payload,
    output logic                 out_v,
    input  logic                 out_a,
    output logic                 busy
);

    localparam int NCHUNK = (Nin + NPCdata - 1) / NPCdata;
    localparam int NSEL   = (NIN > 1) ? $clog2(NIN) : 1;
    localparam int NCW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int SHW    = NCHUNK * NPCdata;

    typedef enum logic {IDLE, SEND} state_t;

    state_t          state;
    logic [NSEL-1:0] rr_ptr;
    logic [NSEL-1:0] gsel;
    logic [NSEL-1:0] grant;
    logic            grant_found;
    logic [NCW-1:0]  chunk_cnt;
    logic [SHW-1:0]  sh;
    logic [SHW-1:0]  sh_next;
    logic [SHW-1:0]  load_val;
    logic [NIN-1:0]  req;
    logic            last_chunk;

    assign req        = in_v & enable;
    assign sh_next    = sh >> NPCdata;
    assign last_chunk = (chunk_cnt == NCW'(NCHUNK - 1));
    assign load_val   = SHW'(in_d[int'(grant)*Nin +: Nin]);

    // First requesting stream found when scanning upward from rr_ptr, wrapping at NIN.
    always_comb begin
        int idx;
        // NOTE: every always_comb output gets a default up front so no path can infer a latch.
        idx         = 0;
        grant       = '0;
        grant_found = 1'b0;
        for (int k = 0; k < NIN; k++) begin
            idx = (int'(rr_ptr) + k) % NIN;
            if (!grant_found && req[idx]) begin
                grant_found = 1'b1;
                grant       = NSEL'(idx);
            end
        end
    end

    // Ack is only ever offered from IDLE, so it can never coincide with out_v.
    always_comb begin
        in_a = '0;
        if (state == IDLE && grant_found)
            in_a[grant] = 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            gsel        <= '0;
            chunk_cnt   <= '0;
            sh          <= '0;
            out_v       <= 1'b0;
            busy        <= 1'b0;
            out_code    <= '0;
            out_payload <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        sh          <= load_val;
                        gsel        <= grant;
                        chunk_cnt   <= '0;
                        out_v       <= 1'b1;
                        busy        <= 1'b1;
                        out_code    <= NPCcode'(CODE_BASE + int'(grant));
                        out_payload <= load_val[NPCdata-1:0];
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (out_a) begin
                        sh          <= sh_next;
                        chunk_cnt   <= chunk_cnt + 1'b1;
                        out_payload <= sh_next[NPCdata-1:0];
                        if (last_chunk) begin
                            rr_ptr <= NSEL'((int'(gsel) + 1) % NIN);
                            out_v  <= 1'b0;
                            busy   <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_stream_serializer_rr.sv
// Scoreboard bench for pc_stream_serializer_rr: default 4x48-bit instance plus a
// 2x30-bit instance for the padded final chunk.
module tb_pc_stream_serializer_rr;

    localparam int NIN = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NIN*48-1:0] in_d = '0;
    logic [NIN-1:0]    in_v = '0;
    logic [NIN-1:0]    in_a;
    logic [NIN-1:0]    enable = '1;
    logic [7:0]        out_code;
    logic [23:0]       out_payload;
    logic              out_v;
    logic              out_a = 1'b1;
    logic              busy;

    logic [59:0]       in_d30 = '0;
    logic [1:0]        in_v30 = '0;
    logic [1:0]        in_a30;
    logic [1:0]        enable30 = '1;
    logic [7:0]        out_code30;
    logic [23:0]       out_payload30;
    logic              out_v30;
    logic              out_a30 = 1'b1;
    logic              busy30;

    pc_stream_serializer_rr u_dut (
        .clk(clk), .reset(reset), .in_d(in_d), .in_v(in_v), .in_a(in_a),
        .enable(enable), .out_code(out_code), .out_payload(out_payload),
        .out_v(out_v), .out_a(out_a), .busy(busy)
    );

    pc_stream_serializer_rr #(.NIN(2), .Nin(30)) u_dut30 (
        .clk(clk), .reset(reset), .in_d(in_d30), .in_v(in_v30), .in_a(in_a30),
        .enable(enable30), .out_code(out_code30), .out_payload(out_payload30),
        .out_v(out_v30), .out_a(out_a30), .busy(busy30)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  code;
        logic [23:0] pay;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    int          grant_q[$];
    int          src_left[NIN];
    logic [47:0] src_val[NIN];
    int          grant_cnt[NIN];
    int          n_checks = 0;
    int          n_fail = 0;
    bit          lat_pending = 1'b0;
    bit          gap_pending = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_sources();
        for (int i = 0; i < NIN; i++) begin
            in_v[i]          = (src_left[i] > 0);
            in_d[i*48 +: 48] = src_val[i];
        end
    endtask

    task automatic push_msg(input int s, input logic [47:0] d);
        exp_t e;
        e.code = 8'(14 + s);
        e.pay  = d[23:0];
        e.last = 1'b0;
        exp_q.push_back(e);
        e.pay  = d[47:24];
        e.last = 1'b1;
        exp_q.push_back(e);
    endtask

    // One cycle per iteration: observe at negedge, update sources just after posedge.
    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            int   acked;
            exp_t e;
            acked = -1;
            @(negedge clk);
            if (lat_pending) begin
                check("lat_out_v", out_v, 1);
                check("lat_busy", busy, 1);
                lat_pending = 1'b0;
            end
            if (gap_pending) begin
                check("gap_out_v", out_v, 0);
                gap_pending = 1'b0;
            end
            if (out_v)
                check("ack_in_send", in_a, 0);
            if (out_v && out_a) begin
                check("word_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("code", out_code, e.code);
                    check("payload", out_payload, e.pay);
                    if (e.last)
                        gap_pending = 1'b1;
                end
            end
            if (in_a != 0) begin
                check("ack_onehot", $onehot(in_a), 1);
                for (int i = NIN - 1; i >= 0; i--)
                    if (in_a[i]) acked = i;
                check("grant_expected", grant_q.size() > 0, 1);
                if (grant_q.size() > 0)
                    check("grant", acked, grant_q.pop_front());
                push_msg(acked, src_val[acked]);
                grant_cnt[acked]++;
                lat_pending = 1'b1;
            end
            @(posedge clk);
            #1;
            if (acked >= 0) begin
                src_left[acked]--;
                src_val[acked] = src_val[acked] + 48'd1;
                drive_sources();
            end
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        grant_q.delete();
        lat_pending = 1'b0;
        gap_pending = 1'b0;
        for (int i = 0; i < NIN; i++) begin
            src_left[i]  = 0;
            src_val[i]   = '0;
            grant_cnt[i] = 0;
        end
        drive_sources();
    endtask

    task automatic do_reset();
        clear_model();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        out_a = 1'b1;
        enable = '1;
    endtask

    task automatic finish_test(input string name);
        check({name, "_sb_empty"}, exp_q.size(), 0);
        check({name, "_grants_done"}, grant_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        do_reset();
        @(negedge clk);
        check("rst_out_v", out_v, 0);
        check("rst_in_a", in_a, 0);
        check("rst_out_code", out_code, 0);
        check("rst_out_payload", out_payload, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1;

        // Single message on stream 2, out_a tied high
        src_val[2]  = 48'hABCDEF123456;
        src_left[2] = 1;
        grant_q.push_back(2);
        drive_sources();
        run_cycles(6);
        check("t1_idle_out_v", out_v, 0);
        check("t1_idle_busy", busy, 0);
        check("t1_ack_count", grant_cnt[2], 1);
        finish_test("t1");

        // Nin=30: upper chunk zero-padded
        in_d30[29:0] = 30'h3FFFFFFF;
        in_v30       = 2'b01;
        @(negedge clk);
        check("n30_ack", in_a30, 2'b01);
        @(posedge clk);
        #1;
        in_v30 = 2'b00;
        @(negedge clk);
        check("n30_v0", out_v30, 1);
        check("n30_code0", out_code30, 14);
        check("n30_pay0", out_payload30, 24'hFFFFFF);
        @(posedge clk);
        @(negedge clk);
        check("n30_v1", out_v30, 1);
        check("n30_code1", out_code30, 14);
        check("n30_pay1", out_payload30, 24'h00003F);
        @(posedge clk);
        @(negedge clk);
        check("n30_idle", out_v30, 0);
        @(posedge clk);
        #1;

        // All streams continuously valid: strict rotation, no interleave
        do_reset();
        for (int i = 0; i < NIN; i++) begin
            src_left[i] = 2;
            src_val[i]  = 48'h100000_000000 * (i + 1) + 48'h000000_A00000;
        end
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NIN; i++)
                grant_q.push_back(i);
        drive_sources();
        run_cycles(28);
        for (int i = 0; i < NIN; i++)
            check("t3_share", grant_cnt[i], 2);
        finish_test("t3");

        // Backpressure during chunk 0 of stream 1; stream 3 waits unacked
        do_reset();
        out_a       = 1'b0;
        src_val[1]  = 48'h5A5A5A_C3C3C3;
        src_left[1] = 1;
        src_val[3]  = 48'h777777_888888;
        src_left[3] = 1;
        grant_q.push_back(1);
        grant_q.push_back(3);
        drive_sources();
        run_cycles(1);
        lat_pending = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check("stall_v", out_v, 1);
            check("stall_code", out_code, 15);
            check("stall_pay", out_payload, 24'hC3C3C3);
            check("stall_no_ack", in_a, 0);
            @(posedge clk);
            #1;
        end
        out_a = 1'b1;
        run_cycles(10);
        finish_test("t4");

        // Enable mask 1010; clear enable[1] mid-message
        do_reset();
        enable = 4'b1010;
        for (int i = 0; i < NIN; i++) begin
            src_left[i] = 3;
            src_val[i]  = 48'h0F0000_000000 * (i + 1) + 48'h000000_000100;
        end
        grant_q.push_back(1);
        grant_q.push_back(3);
        grant_q.push_back(1);
        drive_sources();
        run_cycles(7);
        enable = 4'b1000;
        grant_q.push_back(3);
        grant_q.push_back(3);
        run_cycles(12);
        check("t5_cnt0", grant_cnt[0], 0);
        check("t5_cnt1", grant_cnt[1], 2);
        check("t5_cnt2", grant_cnt[2], 0);
        check("t5_cnt3", grant_cnt[3], 3);
        finish_test("t5");

        // Reset during chunk 0 of stream 3
        do_reset();
        out_a       = 1'b0;
        src_val[3]  = 48'h333333_444444;
        src_left[3] = 1;
        grant_q.push_back(3);
        drive_sources();
        run_cycles(1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("t6_rst_out_v", out_v, 0);
        check("t6_rst_busy", busy, 0);
        reset = 1'b0;
        clear_model();
        out_a = 1'b1;
        for (int i = 0; i < NIN; i++) begin
            src_left[i] = 1;
            src_val[i]  = 48'hC00000_000000 + 48'h000001_000010 * i;
            grant_q.push_back(i);
        end
        drive_sources();
        run_cycles(14);
        finish_test("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
